// File: rtl/div.sv
// Iterative 32-bit signed/unsigned divider: restoring shift-subtract, one quotient
// bit per cycle, held result handshake with the EX stage via start_i/ready_o.
module div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [64:0] r_dividend;
  logic [31:0] r_divisor;
  logic        r_neg_quo;
  logic        r_neg_rem;
  logic [63:0] r_result;
  logic        r_ready;

  logic [31:0] w_mag1, w_mag2;
  logic [32:0] w_sub;
  logic [31:0] w_quo, w_rem;
  logic        w_load;

  assign w_mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign w_mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
  assign w_load = start_i && !annul_i && (opdata2_i != 32'd0);

  // Trial subtraction; bit 32 set means the divisor does not fit this step.
  assign w_sub = {1'b0, r_dividend[63:32]} - {1'b0, r_divisor};

  assign w_quo = r_neg_quo ? (~r_dividend[31:0] + 32'd1)  : r_dividend[31:0];
  assign w_rem = r_neg_rem ? (~r_dividend[64:33] + 32'd1) : r_dividend[64:33];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= FREE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FREE: begin
        if (start_i && !annul_i)
          w_next = (opdata2_i == 32'd0) ? BYZERO : ON;
      end
      BYZERO: w_next = END;
      ON: begin
        if (annul_i)               w_next = FREE;
        else if (r_cnt == 6'd32)   w_next = END;
      end
      END: begin
        if (!start_i) w_next = FREE;
      end
      default: w_next = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= 6'd0;
      r_dividend <= 65'd0;
      r_divisor  <= 32'd0;
      r_neg_quo  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_result   <= 64'd0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        FREE: begin
          r_cnt    <= 6'd0;
          r_result <= 64'd0;
          r_ready  <= 1'b0;
          if (w_load) begin
            // Operands and sign handling are captured here so later input changes are ignored.
            r_dividend <= {32'd0, w_mag1, 1'b0};
            r_divisor  <= w_mag2;
            r_neg_quo  <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            r_neg_rem  <= signed_div_i && opdata1_i[31];
          end
        end
        BYZERO: begin
          r_result <= 64'd0;
          r_ready  <= 1'b0;
        end
        ON: begin
          if (annul_i) begin
            r_cnt    <= 6'd0;
            r_result <= 64'd0;
            r_ready  <= 1'b0;
          end else if (r_cnt != 6'd32) begin
            if (w_sub[32]) r_dividend <= {r_dividend[63:0], 1'b0};
            else           r_dividend <= {w_sub[31:0], r_dividend[31:0], 1'b1};
            r_cnt <= r_cnt + 6'd1;
          end else begin
            r_result <= {w_rem, w_quo};
          end
        end
        END: begin
          if (start_i) begin
            r_ready <= 1'b1;
          end else begin
            r_ready  <= 1'b0;
            r_result <= 64'd0;
          end
        end
        default: begin
          r_ready  <= 1'b0;
          r_result <= 64'd0;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 clk  input  1  pipeline clock; all state changes on the rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
REQ-003 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
REQ-004 opdata1_i  input  32  dividend, taken from the EX-stage operand 1; sampled with start_i.
REQ-005 opdata2_i  input  32  divisor, taken from the EX-stage operand 2; sampled with start_i.
REQ-006 start_i  input  1  EX-stage division request; level, held high until the result is consumed.
REQ-007 annul_i  input  1  abort the division in progress (pipeline flush).
REQ-008 result_o  output  64  [63:32] = remainder (HI), [31:0] = quotient (LO).
REQ-009 ready_o  output  1  result_o valid; EX holds its stall request while start_i=1 and ready_o=0.

Function
REQ-010 The FSM SHALL have four states: FREE, BYZERO, ON, END.
REQ-011 FREE: start_i=1, annul_i=0, divisor=0 SHALL go to BYZERO; with divisor≠0 it SHALL go to ON, load operands and set the step counter to 0.
REQ-012 FREE with start_i=0 or annul_i=1 SHALL stay FREE, with ready_o=0 and result_o=0.
REQ-013 Signed mode SHALL convert negative operands to two's-complement magnitude at load; unsigned mode SHALL use the operands unchanged.
REQ-014 ON: with annul_i=0 and counter<32, each cycle SHALL perform one restoring shift-subtract step on the 65-bit partial-remainder/quotient register and increment the 6-bit counter.
REQ-015 ON: with counter=32, the block SHALL apply the sign fix and then go to END.
  - quotient negated if signs differ (signed only)
  - remainder negated if dividend negative (signed only)
REQ-016 ON: annul_i=1 SHALL return to FREE on the next edge, clear the counter, and keep ready_o=0 and result_o=0.
REQ-017 BYZERO SHALL go to END on the next edge with result = 64'h0.
REQ-018 END SHALL drive ready_o=1 and hold result_o stable.
REQ-019 END with start_i=0 SHALL go to FREE; ready_o and result_o SHALL then be 0.
REQ-020 END with start_i=1 SHALL stay in END, with no new division started, whatever annul_i is.
REQ-021 Latency: ready_o SHALL first be high after the 34th rising edge following the edge that sampled start_i (divisor≠0), and after the 2nd such edge for a divisor of 0.
REQ-022 Operand or signed_div_i changes after the sampling edge SHALL NOT affect the result.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0, with no trap or flag.
REQ-024 Signed results SHALL meet dividend = quotient*divisor + remainder, with |remainder| < |divisor|.

Reset
REQ-025 When rst_n=0 at a rising edge, the block SHALL apply all of the following, from any state:
  - state = FREE
  - counter = 0
  - internal dividend/divisor registers = 0
  - result_o = 64'h0
  - ready_o = 0
REQ-026 Reset SHALL take priority over start_i and annul_i.
REQ-027 An operation cut by reset SHALL produce no ready_o pulse.

Verification
REQ-028 Unsigned 100 / 7, start_i held -> ready_o high 34 edges later, result_o = {32'd2, 32'd14}; drop start_i -> ready_o=0 and result_o=0 next edge.
REQ-029 Signed -7 / 2 -> result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}; signed 7 / -2 -> {32'h00000001, 32'hFFFFFFFD}.
REQ-030 Any dividend / 0 (signed and unsigned) -> ready_o high 2 edges after start, result_o = 64'h0.
REQ-031 annul_i=1 for one cycle at step 10 -> FREE next edge, ready_o never rises; a fresh start of 0xFFFFFFFF / 1 unsigned -> {32'h0, 32'hFFFFFFFF}.
REQ-032 rst_n=0 at step 20 -> result_o=0, ready_o=0, FREE; after release, a start of signed 0x80000000 / 0xFFFFFFFF -> {32'h0, 32'h80000000}.
REQ-033 start_i held high 5 cycles in END -> result_o stable, ready_o=1 throughout, no restart.
